slot_stopper: RTL

SLOT_STOPPER -- requirements
Module: slot_stopper

---
 rtl/slot_stopper.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/slot_stopper.sv
// Three-reel slot stopper: synchronized button/reel-tick inputs, a five-state
// stop sequencer, modulo reel counters and registered win flags.
module slot_stopper #(
    parameter int DIGIT_MAX   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gameselect,
    input  logic       btn2,
    input  logic       gameout1,
    input  logic       gameout2,
    input  logic       gameout3,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [3:0] reel3,
    output logic [2:0] running,
    output logic       done,
    output logic       win_jackpot,
    output logic       win_pair
);

    // state  | meaning
    // IDLE   | game off, reels frozen
    // SPIN   | all three reels advancing
    // STOP1  | reel1 frozen, reels 2 and 3 advancing
    // STOP2  | reels 1 and 2 frozen, reel3 advancing
    // RESULT | all reels frozen, win flags valid
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPIN   = 3'd1,
        STOP1  = 3'd2,
        STOP2  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

    // Index 0 is the button, 1..3 are the reel ticks.
    logic [3:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             edge_q;
    logic [3:0]             pulse;

    state_t          state_q, state_d;
    logic [2:0][3:0] reel_q, reel_d;
    logic            jp_q, jp_d;
    logic            pair_q, pair_d;
    logic [2:0]      run_c;
    logic [2:0]      stop_m;
    logic [2:0]      adv;
    logic            btn_p;
    logic            jp_c, pair_c;

    assign raw = {gameout3, gameout2, gameout1, btn2};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) sync_q[i] <= '0;
            edge_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
                edge_q[i] <= sync_q[i][SYNC_STAGES-1];
            end
        end
    end

    always_comb begin
        pulse = '0;
        for (int i = 0; i < 4; i++) pulse[i] = sync_q[i][SYNC_STAGES-1] & ~edge_q[i];
    end

    assign btn_p = pulse[0];

    function automatic logic [3:0] bump(input logic [3:0] v);
        return (v == DMAX) ? 4'd0 : v + 4'd1;
    endfunction

    // Reel3 cannot advance on the cycle that enters RESULT, so its current
    // value is already the final one.
    assign jp_c   = (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]);
    assign pair_c = !jp_c && ((reel_q[0] == reel_q[1]) || (reel_q[1] == reel_q[2]) ||
                              (reel_q[0] == reel_q[2]));

    always_comb begin
        run_c  = 3'b000;
        stop_m = 3'b000;
        case (state_q)
            SPIN:    begin run_c = 3'b111; stop_m = {2'b00, btn_p}; end
            STOP1:   begin run_c = 3'b110; stop_m = {1'b0, btn_p, 1'b0}; end
            STOP2:   begin run_c = 3'b100; stop_m = {btn_p, 2'b00}; end
            default: begin run_c = 3'b000; stop_m = 3'b000; end
        endcase
    end

    // A stop pulse beats a tick on the reel it freezes.
    assign adv = gameselect ? (run_c & ~stop_m & pulse[3:1]) : 3'b000;

    always_comb begin
        state_d = state_q;
        jp_d    = jp_q;
        pair_d  = pair_q;
        reel_d  = reel_q;
        for (int i = 0; i < 3; i++) begin
            if (adv[i]) reel_d[i] = bump(reel_q[i]);
        end
        if (!gameselect) begin
            state_d = IDLE;
            jp_d    = 1'b0;
            pair_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE:  if (btn_p) state_d = SPIN;
                SPIN:  if (btn_p) state_d = STOP1;
                STOP1: if (btn_p) state_d = STOP2;
                STOP2: if (btn_p) begin
                    state_d = RESULT;
                    jp_d    = jp_c;
                    pair_d  = pair_c;
                end
                RESULT: if (btn_p) begin
                    state_d = SPIN;
                    jp_d    = 1'b0;
                    pair_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            reel_q  <= '0;
            jp_q    <= 1'b0;
            pair_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reel_q  <= reel_d;
            jp_q    <= jp_d;
            pair_q  <= pair_d;
        end
    end

    assign reel1       = reel_q[0];
    assign reel2       = reel_q[1];
    assign reel3       = reel_q[2];
    assign running     = run_c;
    assign done        = (state_q == RESULT);
    assign win_jackpot = jp_q;
    assign win_pair    = pair_q;

endmodule
